// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the unified instruction/data memory path:
// access-size encodings, arbiter state encoding and memory map constants.
package riscv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int DATA_REGION_OFFSET = 2048;

    localparam int STARVE_W = 4;
    localparam int PERF_W   = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DATA  = 2'd2
    } arb_state_t;

    // A simultaneous read+write request is executed as a store.
    function automatic logic is_load(input logic rd, input logic wr);
        return rd & ~wr;
    endfunction

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear; used for the fetch
// starvation counter and the optional stall performance counters.
module arb_sat_counter #(
    parameter int                 WIDTH = 4,
    parameter logic [WIDTH-1:0]   MAX   = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    // NOTE: sequential state is always assigned with <= so every flop samples
    // pre-edge values regardless of the order in which processes evaluate.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbiter for the single-ported unified memory shared by fetch and load/store.
// Optional stall perf counters are built when ARB_PERF_CNT_EN is defined.
module unified_mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_stall,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [2:0]        d_func3,
    output logic              d_gnt,
    output logic              d_stall,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_func3,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic [15:0]       fetch_stall_cnt,
    output logic [15:0]       data_stall_cnt
);

    localparam logic [STARVE_W-1:0] STARVE_LIMIT = STARVE_W'(STARVE_MAX);

    logic                d_any;
    logic                force_if;
    logic [STARVE_W-1:0] starve_cnt;
    arb_state_t          state;
    arb_state_t          state_next;

    // ------------------------------------------------------------------
    // Arbitration: data wins unless fetch has been denied STARVE_MAX times.
    // ------------------------------------------------------------------
    assign d_any    = d_read | d_write;
    assign force_if = if_req & (starve_cnt == STARVE_LIMIT);
    assign d_gnt    = d_any & ~force_if;
    assign if_gnt   = if_req & ~d_gnt;
    assign if_stall = if_req & ~if_gnt;
    assign d_stall  = d_any & ~d_gnt;

    arb_sat_counter #(
        .WIDTH (STARVE_W),
        .MAX   (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk (clk),
        .rst (rst),
        .clr (if_gnt | ~if_req),
        .inc (if_stall),
        .cnt (starve_cnt)
    );

    // ------------------------------------------------------------------
    // Owner FSM: records who held the memory in the previous cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first so
        // no path through the block leaves it unassigned and infers a latch.
        state_next = S_IDLE;
        if (d_gnt) begin
            state_next = S_DATA;
        end else if (if_gnt) begin
            state_next = S_FETCH;
        end
    end

    // ------------------------------------------------------------------
    // Memory drive from the current owner.
    // ------------------------------------------------------------------
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_func3 = 3'b000;
        if (d_gnt) begin
            mem_read  = is_load(d_read, d_write);
            mem_write = d_write;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_func3 = d_func3;
        end else if (if_gnt) begin
            mem_addr  = if_addr;
            mem_func3 = F3_W;
        end
    end

    // ------------------------------------------------------------------
    // Registered responses; a response due while rst is sampled is dropped.
    // ------------------------------------------------------------------
    assign if_valid = (state == S_FETCH);

    always_ff @(posedge clk) begin
        if (rst) begin
            if_rdata <= '0;
            d_rdata  <= '0;
            d_valid  <= 1'b0;
            d_err    <= 1'b0;
        end else begin
            if (if_gnt) begin
                if_rdata <= mem_rdata;
            end
            d_valid <= d_gnt & is_load(d_read, d_write);
            if (d_gnt && is_load(d_read, d_write)) begin
                d_rdata <= mem_rdata;
            end
            d_err <= d_gnt & d_read & d_write;
        end
    end

    // ------------------------------------------------------------------
    // Optional stall performance counters.
    // ------------------------------------------------------------------
`ifdef ARB_PERF_CNT_EN
    arb_sat_counter #(
        .WIDTH (PERF_W),
        .MAX   ({PERF_W{1'b1}})
    ) u_fetch_stall_cnt (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (if_stall),
        .cnt (fetch_stall_cnt)
    );

    arb_sat_counter #(
        .WIDTH (PERF_W),
        .MAX   ({PERF_W{1'b1}})
    ) u_data_stall_cnt (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (d_stall),
        .cnt (data_stall_cnt)
    );
`else
    assign fetch_stall_cnt = 16'h0000;
    assign data_stall_cnt  = 16'h0000;
`endif

endmodule
